mc_response_stats: RTL and testbench
====================================

Name: mc_response_stats

Overview:
Downstream consumer of the Monte Carlo accelerator's response stream. It accepts unsigned 32-bit results over a ready/valid handshake and accumulates count, sum, min and max over a configurable batch. It then presents one summary record over a second ready/valid handshake. It lets the top level check or print batch statistics instead of every individual result.

Parameters:
DATA_W, 32, width of one accelerator response (unsigned)
COUNT_W, 16, width of the batch-size and sample counters
SUM_W, 48, width of the running sum accumulator

Ports:
clock  input  1  single clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
cfg_batch_size  input  COUNT_W  samples per batch; sampled on the first accepted sample of each batch
in_valid  input  1  response valid (driven by accelerator io_response_valid)
in_ready  output  1  block can accept a response (drives accelerator io_response_ready)
in_bits  input  DATA_W  response value
out_valid  output  1  summary record valid
out_ready  input  1  summary consumer ready
out_count  output  COUNT_W  samples in this batch
out_sum  output  SUM_W  sum of samples, modulo 2^SUM_W
out_sum_ovf  output  1  sum wrapped at least once during this batch
out_min  output  DATA_W  smallest sample in batch
out_max  output  DATA_W  largest sample in batch
busy  output  1  at least one sample accepted in the current, not-yet-emitted batch

Behaviour:
- Reset (sync, active-high; wins over all other inputs on the same edge): state=ACCUM; count=0; sum=0; ovf=0; min=all-ones; max=0; out_valid=0; busy=0; latched batch size=1. Reset mid-batch or mid-EMIT discards the partial or pending record with no output.
- State ACCUM:
  - in_ready=1 and out_valid=0.
  - Accept when in_valid & in_ready.
  - On accept with count==0: latch target = (cfg_batch_size==0) ? 1 : cfg_batch_size.
  - Changes to cfg_batch_size after that accept are ignored until the next batch.
  - On every accept: count+=1; sum = sum + zero-extended in_bits, truncated to SUM_W; ovf |= carry-out; min = min(min, in_bits); max = max(max, in_bits).
  - Comparisons are unsigned. The first sample sets min and max by virtue of the reset and clear values.
  - When the accept brings count to target: go to EMIT on the same edge. Registers hold the final values, so the summary is valid the cycle after the final accept (latency 1).
- State EMIT:
  - out_valid=1 and in_ready=0. The accelerator is back-pressured and no sample is lost.
  - Outputs are driven from registers and stay stable while out_valid & !out_ready.
  - On out_valid & out_ready: clear count, sum, ovf, min and max to their reset values; go to ACCUM. in_ready returns to 1 on the next cycle.
- busy = (count != 0) | out_valid.
- out_* payload pins are don't-care while out_valid=0. The bench checks them only on handshake.
- Count never exceeds target, so the counter does not wrap. The maximum batch is 2^COUNT_W - 1.
- A sample equal to the current min or max leaves it unchanged, with no side effect.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- One summary per batch. No internal FIFO.
- Throughput: N samples in N cycles, plus one EMIT cycle minimum per batch.

Test Plan:
- Basic batch: batch=4, in_valid continuous with 10, 3, 7, 20 -> one record: count=4, sum=40, min=3, max=20, ovf=0; out_valid asserted 1 cycle after the 4th accept.
- Output backpressure: as above, with out_ready=0 for 5 cycles after out_valid -> record stable all 5 cycles, in_ready=0 throughout, no input accepted; next batch starts the cycle after the handshake.
- Batch size 0 and reconfigure: cfg_batch_size=0, inputs 5 then 9 -> two records, each count=1 (sum/min/max=5, then 9). Then set batch=3 and change cfg to 8 after the first accept -> record has count=3.
- Overflow: SUM_W=32, batch=2, inputs 0xFFFFFFFF, 0xFFFFFFFF -> sum=0xFFFFFFFE, ovf=1, min=max=0xFFFFFFFF; the next batch with 1, 2 gives ovf=0, sum=3.
- Reset mid-operation: batch=4, accept 2 samples, pulse reset one cycle, then feed 1, 2, 3, 4 -> only one record (count=4, sum=10, min=1, max=4). Reset asserted during EMIT -> out_valid=0 the next cycle and the record is dropped.
- Gapped input: batch=3, in_valid toggling 1,0,0,1,0,1 with values 100, 50, 75 -> count=3, sum=225, min=50, max=100; busy=1 from the first accept until the output handshake.

Source files
------------

// File: rtl/mc_response_stats.sv
// Batch statistics collector for the Monte Carlo response stream.
// Accumulates count/sum/min/max over a batch and emits one summary record per batch.
module mc_response_stats #(
    parameter int DATA_W  = 32,
    parameter int COUNT_W = 16,
    parameter int SUM_W   = 48
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [COUNT_W-1:0] cfg_batch_size,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_bits,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COUNT_W-1:0] out_count,
    output logic [SUM_W-1:0]   out_sum,
    output logic               out_sum_ovf,
    output logic [DATA_W-1:0]  out_min,
    output logic [DATA_W-1:0]  out_max,
    output logic               busy
);

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] target_q, target_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic               ovf_q, ovf_d;
    logic [DATA_W-1:0]  min_q, min_d;
    logic [DATA_W-1:0]  max_q, max_d;

    logic               accept;
    logic [COUNT_W-1:0] batch_tgt;
    logic [SUM_W:0]     sum_ext;

    function automatic logic [DATA_W-1:0] umin(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return (b < a) ? b : a;
    endfunction

    function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return (b > a) ? b : a;
    endfunction

    // A zero batch size is treated as one so every batch emits at least one sample.
    function automatic logic [COUNT_W-1:0] batch_target(input logic [COUNT_W-1:0] cfg);
        return (cfg == '0) ? COUNT_W'(1) : cfg;
    endfunction

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == EMIT);
    assign accept    = in_valid & in_ready;
    assign busy      = (count_q != '0) | out_valid;

    assign out_count   = count_q;
    assign out_sum     = sum_q;
    assign out_sum_ovf = ovf_q;
    assign out_min     = min_q;
    assign out_max     = max_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        target_d  = target_q;
        sum_d     = sum_q;
        ovf_d     = ovf_q;
        min_d     = min_q;
        max_d     = max_q;
        batch_tgt = target_q;
        sum_ext   = {1'b0, sum_q} + {{(SUM_W + 1 - DATA_W){1'b0}}, in_bits};

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    // The batch size is captured only on the first sample of a batch.
                    if (count_q == '0) begin
                        batch_tgt = batch_target(cfg_batch_size);
                    end
                    target_d = batch_tgt;
                    count_d  = count_q + COUNT_W'(1);
                    sum_d    = sum_ext[SUM_W-1:0];
                    ovf_d    = ovf_q | sum_ext[SUM_W];
                    min_d    = umin(min_q, in_bits);
                    max_d    = umax(max_q, in_bits);
                    if (count_d == batch_tgt) begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    count_d = '0;
                    sum_d   = '0;
                    ovf_d   = 1'b0;
                    min_d   = '1;
                    max_d   = '0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ACCUM;
            count_q  <= '0;
            target_q <= COUNT_W'(1);
            sum_q    <= '0;
            ovf_q    <= 1'b0;
            min_q    <= '1;
            max_q    <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            target_q <= target_d;
            sum_q    <= sum_d;
            ovf_q    <= ovf_d;
            min_q    <= min_d;
            max_q    <= max_d;
        end
    end

endmodule

// File: tb/tb_mc_response_stats.sv
// Directed bench for mc_response_stats: table-driven batches plus hand-written
// sequences for backpressure, reconfiguration, reset and gapped input.
module tb_mc_response_stats;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cfg_batch_size = 16'd1;
    logic        in_valid = 1'b0;
    logic [31:0] in_bits = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_sum_ovf, busy;
    logic [15:0] out_count;
    logic [47:0] out_sum;
    logic [31:0] out_min, out_max;

    logic        in_ready32, out_valid32, out_sum_ovf32, busy32;
    logic [15:0] out_count32;
    logic [31:0] out_sum32;
    logic [31:0] out_min32, out_max32;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mc_response_stats dut (
        .clock(clock), .reset(reset), .cfg_batch_size(cfg_batch_size),
        .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
        .out_sum(out_sum), .out_sum_ovf(out_sum_ovf), .out_min(out_min),
        .out_max(out_max), .busy(busy)
    );

    mc_response_stats #(.SUM_W(32)) dut32 (
        .clock(clock), .reset(reset), .cfg_batch_size(cfg_batch_size),
        .in_valid(in_valid), .in_ready(in_ready32), .in_bits(in_bits),
        .out_valid(out_valid32), .out_ready(out_ready), .out_count(out_count32),
        .out_sum(out_sum32), .out_sum_ovf(out_sum_ovf32), .out_min(out_min32),
        .out_max(out_max32), .busy(busy32)
    );

    typedef struct packed {
        logic [15:0]      batch;
        logic [2:0]       n;
        logic [3:0][31:0] data;
        logic [15:0]      cnt;
        logic [47:0]      sum48;
        logic             ovf48;
        logic [31:0]      sum32;
        logic             ovf32;
        logic [31:0]      mn;
        logic [31:0]      mx;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] b, input logic [2:0] n,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [15:0] c, input logic [47:0] s48,
                                input logic o48, input logic [31:0] s32,
                                input logic o32, input logic [31:0] mn,
                                input logic [31:0] mx);
        vec_t v;
        v.batch = b; v.n = n;
        v.data[0] = d0; v.data[1] = d1; v.data[2] = d2; v.data[3] = d3;
        v.cnt = c; v.sum48 = s48; v.ovf48 = o48; v.sum32 = s32; v.ovf32 = o32;
        v.mn = mn; v.mx = mx;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_record(input string tag, input logic [15:0] c,
                                input logic [47:0] s, input logic o,
                                input logic [31:0] mn, input logic [31:0] mx);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".count"},     64'(out_count), 64'(c));
        chk({tag, ".sum"},       64'(out_sum),   64'(s));
        chk({tag, ".ovf"},       64'(out_sum_ovf), 64'(o));
        chk({tag, ".min"},       64'(out_min),   64'(mn));
        chk({tag, ".max"},       64'(out_max),   64'(mx));
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ".post_hs_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".post_hs_in_ready"},  64'(in_ready),  64'd1);
    endtask

    task automatic feed(input logic [31:0] v);
        in_valid = 1'b1;
        in_bits  = v;
        step();
        in_valid = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = mk(16'd4, 3'd4, 32'd10, 32'd3, 32'd7, 32'd20, 16'd4,
                     48'd40, 1'b0, 32'd40, 1'b0, 32'd3, 32'd20);
        vecs[1] = mk(16'd0, 3'd1, 32'd5, 32'd0, 32'd0, 32'd0, 16'd1,
                     48'd5, 1'b0, 32'd5, 1'b0, 32'd5, 32'd5);
        vecs[2] = mk(16'd0, 3'd1, 32'd9, 32'd0, 32'd0, 32'd0, 16'd1,
                     48'd9, 1'b0, 32'd9, 1'b0, 32'd9, 32'd9);
        vecs[3] = mk(16'd2, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 16'd2,
                     48'h1_FFFF_FFFE, 1'b0, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        vecs[4] = mk(16'd2, 3'd2, 32'd1, 32'd2, 32'd0, 32'd0, 16'd2,
                     48'd3, 1'b0, 32'd3, 1'b0, 32'd1, 32'd2);
        vecs[5] = mk(16'd3, 3'd3, 32'd7, 32'd7, 32'd7, 32'd0, 16'd3,
                     48'd21, 1'b0, 32'd21, 1'b0, 32'd7, 32'd7);
        vecs[6] = mk(16'd1, 3'd1, 32'd0, 32'd0, 32'd0, 32'd0, 16'd1,
                     48'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        vecs[7] = mk(16'd4, 3'd4, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'd0, 16'd4,
                     48'h1_8000_0000, 1'b0, 32'h8000_0000, 1'b1, 32'd0, 32'hFFFF_FFFF);

        // Reset state
        step();
        step();
        chk("rst.in_ready",  64'(in_ready),  64'd1);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.busy",      64'(busy),      64'd0);
        reset = 1'b0;
        step();
        chk("idle.busy", 64'(busy), 64'd0);

        // Table-driven batches with continuous input
        for (int v = 0; v < 8; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            cfg_batch_size = vecs[v].batch;
            for (int i = 0; i < int'(vecs[v].n); i++) begin
                if (i == int'(vecs[v].n) - 1)
                    chk({tag, ".pre_last_out_valid"}, 64'(out_valid), 64'd0);
                in_valid = 1'b1;
                in_bits  = vecs[v].data[i];
                step();
            end
            in_valid = 1'b0;
            check_record(tag, vecs[v].cnt, vecs[v].sum48, vecs[v].ovf48,
                         vecs[v].mn, vecs[v].mx);
            chk({tag, ".in_ready_emit"}, 64'(in_ready), 64'd0);
            chk({tag, ".sum32"}, 64'(out_sum32), 64'(vecs[v].sum32));
            chk({tag, ".ovf32"}, 64'(out_sum_ovf32), 64'(vecs[v].ovf32));
            chk({tag, ".valid32"}, 64'(out_valid32), 64'd1);
            handshake(tag);
        end

        // Output backpressure: record held while the accelerator keeps offering data
        cfg_batch_size = 16'd4;
        feed(32'd10); feed(32'd3); feed(32'd7); feed(32'd20);
        in_valid = 1'b1;
        in_bits  = 32'd99;
        cfg_batch_size = 16'd1;
        for (int c = 0; c < 5; c++) begin
            check_record($sformatf("bp%0d", c), 16'd4, 48'd40, 1'b0, 32'd3, 32'd20);
            chk($sformatf("bp%0d.in_ready", c), 64'(in_ready), 64'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp.hs_in_ready", 64'(in_ready), 64'd1);
        chk("bp.hs_busy", 64'(busy), 64'd0);
        step();
        in_valid = 1'b0;
        check_record("bp.next", 16'd1, 48'd99, 1'b0, 32'd99, 32'd99);
        handshake("bp.next");

        // Batch size changed after the first accept is ignored until the next batch
        cfg_batch_size = 16'd3;
        feed(32'd1);
        cfg_batch_size = 16'd8;
        feed(32'd2);
        chk("reconf.mid_valid", 64'(out_valid), 64'd0);
        feed(32'd3);
        check_record("reconf", 16'd3, 48'd6, 1'b0, 32'd1, 32'd3);
        handshake("reconf");

        // Reset mid-batch discards the partial record
        cfg_batch_size = 16'd4;
        feed(32'd50); feed(32'd60);
        chk("rstmid.busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstmid.busy", 64'(busy), 64'd0);
        chk("rstmid.out_valid", 64'(out_valid), 64'd0);
        feed(32'd1); feed(32'd2); feed(32'd3);
        chk("rstmid.no_early_valid", 64'(out_valid), 64'd0);
        feed(32'd4);
        check_record("rstmid", 16'd4, 48'd10, 1'b0, 32'd1, 32'd4);
        handshake("rstmid");

        // Reset during EMIT drops the pending record
        cfg_batch_size = 16'd1;
        feed(32'd42);
        chk("rstemit.valid_before", 64'(out_valid), 64'd1);
        reset = 1'b1;
        out_ready = 1'b0;
        step();
        reset = 1'b0;
        chk("rstemit.out_valid", 64'(out_valid), 64'd0);
        chk("rstemit.busy", 64'(busy), 64'd0);
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        chk("rstemit.stays_idle", 64'(out_valid), 64'd0);

        // Gapped input: valid pattern 1,0,0,1,0,1
        cfg_batch_size = 16'd3;
        feed(32'd100);
        chk("gap.busy0", 64'(busy), 64'd1);
        in_bits = 32'd12345;
        step();
        chk("gap.busy1", 64'(busy), 64'd1);
        step();
        chk("gap.busy2", 64'(busy), 64'd1);
        feed(32'd50);
        step();
        chk("gap.busy4", 64'(busy), 64'd1);
        chk("gap.no_early_valid", 64'(out_valid), 64'd0);
        feed(32'd75);
        check_record("gap", 16'd3, 48'd225, 1'b0, 32'd50, 32'd100);
        step();
        chk("gap.busy_stall", 64'(busy), 64'd1);
        handshake("gap");
        chk("gap.busy_after", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
